// File: rtl/uart_tx_frame.sv
// UART transmitter, one word per request: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// tx low one cycle after acceptance; new_data ignored while busy or while registered block is high.
module uart_tx_frame #(
    parameter int CLK_PER_BIT = 50,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 tx,
    input  logic                 block,
    output logic                 busy,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 new_data,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 block_q, block_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_last;
    logic                 par_bit;

    assign baud_last = (baud_q == BAUD_LAST);
    // Odd parity inverts the XOR so that data plus parity carries an odd count of ones.
    assign par_bit   = (PARITY == 1) ? ~(^data_q) : (^data_q);
    assign block_d   = block;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = block_q;
                baud_d = '0;
                bit_d  = '0;
                if (!block_q && new_data) begin
                    data_d  = data;
                    state_d = S_START;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx_d = data_q[bit_q];
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                tx_d = par_bit;
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                busy_d  = block_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            block_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            block_q <= block_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1, 7E2, 7O2) with a scoreboard-fed serial receiver per instance.
module tb_uart_tx_frame;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, blk0, nd0;
    logic [7:0] data0;
    logic       rst1, blk1, nd1;
    logic [6:0] data1;
    logic [2:0] tx_w, busy_w, done_w, rst_w;

    assign rst_w = {rst1, rst1, rst0};

    uart_tx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst0), .tx(tx_w[0]), .block(blk0), .busy(busy_w[0]),
        .data(data0), .new_data(nd0), .done(done_w[0]));

    uart_tx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst1), .tx(tx_w[1]), .block(blk1), .busy(busy_w[1]),
        .data(data1), .new_data(nd1), .done(done_w[1]));

    uart_tx_frame #(.CLK_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst1), .tx(tx_w[2]), .block(blk1), .busy(busy_w[2]),
        .data(data1), .new_data(nd1), .done(done_w[2]));

    typedef struct packed {
        logic [8:0] w;
        logic       par;
        logic       abort;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int tests = 0;
    int fails = 0;

    function automatic exp_t mk(input logic [8:0] w, input logic p, input logic a);
        exp_t e;
        e.w     = w;
        e.par   = p;
        e.abort = a;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Receiver: sees a start bit, then samples every cycle of the frame and checks it against the next queued word.
    task automatic monitor(input int idx, input int dbits, input int par, input int sbits);
        exp_t        e;
        logic [15:0] rxb;
        logic [8:0]  word;
        bit          stable, busy_ok, done_ok, aborted, have, stop_ok;
        int          nb, f, b, c;
        forever begin
            @(negedge clk);
            if (rst_w[idx]) continue;
            if (tx_w[idx] !== 1'b0) begin
                check($sformatf("idle_done%0d", idx), done_w[idx], 0);
                continue;
            end
            have = 1'b1;
            case (idx)
                0: if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
                1: if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
                default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
            endcase
            if (!have) begin
                check($sformatf("unexpected_frame%0d", idx), 1, 0);
                continue;
            end
            nb = 1 + dbits + ((par != 0) ? 1 : 0) + sbits;
            f = nb * CPB;
            rxb = '1;
            stable = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
            for (int k = 1; k <= f; k++) begin
                if (k > 1) @(negedge clk);
                if (rst_w[idx]) begin
                    aborted = 1'b1;
                    break;
                end
                b = (k - 1) / CPB;
                c = (k - 1) % CPB;
                if (c == 0) rxb[b] = tx_w[idx];
                else if (tx_w[idx] !== rxb[b]) stable = 1'b0;
                if (busy_w[idx] !== 1'b1) busy_ok = 1'b0;
                if (done_w[idx] !== (k == f)) done_ok = 1'b0;
            end
            if (aborted) begin
                check($sformatf("abort_expected%0d", idx), e.abort, 1);
                continue;
            end
            check($sformatf("abort_missed%0d", idx), e.abort, 0);
            word = '0;
            for (int i = 0; i < dbits; i++) word[i] = rxb[1 + i];
            check($sformatf("word%0d", idx), word, e.w);
            if (par != 0) check($sformatf("parity%0d", idx), rxb[1 + dbits], e.par);
            stop_ok = 1'b1;
            for (int s = 0; s < sbits; s++) if (rxb[nb - 1 - s] !== 1'b1) stop_ok = 1'b0;
            check($sformatf("stop%0d", idx), stop_ok, 1);
            check($sformatf("bit_stable%0d", idx), stable, 1);
            check($sformatf("busy_in_frame%0d", idx), busy_ok, 1);
            check($sformatf("done_at_end%0d", idx), done_ok, 1);
        end
    endtask

    initial monitor(0, 8, 0, 1);
    initial monitor(1, 7, 2, 2);
    initial monitor(2, 7, 1, 2);

    // Called at posedge+1; returns 1 time unit after the acceptance edge.
    task automatic send0(input logic [7:0] w, input logic abort);
        q0.push_back(mk({1'b0, w}, 1'b0, abort));
        data0 = w;
        nd0 = 1'b1;
        @(posedge clk);
        #1 nd0 = 1'b0;
    endtask

    task automatic run0();
        rst0 = 1'b1; blk0 = 1'b0; nd0 = 1'b0; data0 = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst0 = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_w[0], 1);
        check("reset_busy", busy_w[0], 0);
        check("reset_done", done_w[0], 0);

        // 8N1 0xA5: busy rises at the acceptance edge, tx still high until the next one
        @(posedge clk);
        #1 send0(8'hA5, 1'b0);
        @(negedge clk);
        check("accept_busy", busy_w[0], 1);
        check("accept_tx_high", tx_w[0], 1);
        repeat (41) @(posedge clk);
        @(negedge clk);
        check("post_frame_busy", busy_w[0], 0);
        check("post_frame_tx", tx_w[0], 1);

        // back-to-back with new_data held high
        @(posedge clk);
        #1;
        q0.push_back(mk(9'h000, 1'b0, 1'b0));
        q0.push_back(mk(9'h0FF, 1'b0, 1'b0));
        data0 = 8'h00;
        nd0 = 1'b1;
        @(posedge clk);
        #1 data0 = 8'hFF;
        repeat (41) @(posedge clk);
        @(negedge clk);
        check("b2b_gap_tx", tx_w[0], 1);
        check("b2b_gap_busy", busy_w[0], 1);
        nd0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_start", tx_w[0], 0);
        repeat (45) @(posedge clk);

        // blocked before the request
        #1 blk0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 data0 = 8'h3C; nd0 = 1'b1;
        @(posedge clk);
        #1 nd0 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("blocked_busy", busy_w[0], 1);
        check("blocked_tx", tx_w[0], 1);
        @(posedge clk);
        #1 blk0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("unblocked_busy", busy_w[0], 0);

        // block raised mid-frame: frame completes, busy stays high afterwards
        @(posedge clk);
        #1 send0(8'h5A, 1'b0);
        repeat (10) @(posedge clk);
        #1 blk0 = 1'b1;
        repeat (35) @(posedge clk);
        @(negedge clk);
        check("mid_block_busy", busy_w[0], 1);
        check("mid_block_tx", tx_w[0], 1);
        data0 = 8'h11; nd0 = 1'b1;
        @(posedge clk);
        #1 nd0 = 1'b0;
        repeat (4) @(posedge clk);
        #1 blk0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 send0(8'h81, 1'b0);
        repeat (45) @(posedge clk);

        // reset during data bit 3
        #1 send0(8'h96, 1'b1);
        repeat (17) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk);
        #1 rst0 = 1'b0;
        @(negedge clk);
        check("midreset_tx", tx_w[0], 1);
        check("midreset_busy", busy_w[0], 0);
        check("midreset_done", done_w[0], 0);
        repeat (2) @(posedge clk);
        #1 send0(8'hC3, 1'b0);
        repeat (45) @(posedge clk);

        // new word offered mid-frame is ignored
        #1 send0(8'h3C, 1'b0);
        repeat (12) @(posedge clk);
        #1 data0 = 8'hFF; nd0 = 1'b1;
        @(posedge clk);
        #1 nd0 = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    task automatic run1();
        rst1 = 1'b1; blk1 = 1'b0; nd1 = 1'b0; data1 = 7'h00;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
        repeat (2) @(posedge clk);
        // 0x03: two ones -> even parity 0, odd parity 1
        #1;
        q1.push_back(mk(9'h003, 1'b0, 1'b0));
        q2.push_back(mk(9'h003, 1'b1, 1'b0));
        data1 = 7'h03; nd1 = 1'b1;
        @(posedge clk);
        #1 nd1 = 1'b0;
        repeat (50) @(posedge clk);
        // 0x54: three ones -> even parity 1, odd parity 0
        #1;
        q1.push_back(mk(9'h054, 1'b1, 1'b0));
        q2.push_back(mk(9'h054, 1'b0, 1'b0));
        data1 = 7'h54; nd1 = 1'b1;
        @(posedge clk);
        #1 nd1 = 1'b0;
        repeat (50) @(posedge clk);
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        repeat (5) @(posedge clk);
        check("frames_missing0", q0.size(), 0);
        check("frames_missing1", q1.size(), 0);
        check("frames_missing2", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
